// File: rtl/servant_uart_pkg.sv
// Shared constants for the servant UART blocks: register map, STATUS/DATA bit
// positions and receiver state encodings.
package servant_uart_pkg;

    localparam logic REG_DATA   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERRUN   = 2;
    localparam int STAT_FRAME_ERR = 3;
    localparam int STAT_COUNT_LSB = 8;

    localparam int DATA_VALID_BIT = 9;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/servant_uart_rx_if.sv
// Wishbone slave bundle for the UART receiver register window.
interface servant_uart_rx_if;
    logic        adr;
    logic [31:0] dat;
    logic        we;
    logic        cyc;
    logic [31:0] rdt;
    logic        ack;

    modport master (output adr, dat, we, cyc, input rdt, ack);
    modport slave  (input adr, dat, we, cyc, output rdt, ack);
endinterface

// File: rtl/servant_sync_fifo.sv
// Single-clock FIFO with occupancy count; head is the oldest entry.
module servant_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == FULL_COUNT);
    assign pop_ok  = pop && !empty;
    // A full FIFO still takes a push when an entry leaves in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/servant_uart_rx.sv
// 8N1 UART receiver with a receive FIFO behind a Wishbone DATA/STATUS window.
module servant_uart_rx
    import servant_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 278,
    parameter int FIFO_DEPTH   = 16,
    parameter int AW           = $clog2(FIFO_DEPTH)
) (
    input  logic              i_wb_clk,
    input  logic              i_wb_rst,
    input  logic              i_rx,
    servant_uart_rx_if.slave  wb,
    output logic              o_irq
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    logic [1:0]    sync_reg;
    logic          rx_s;
    rx_state_e     state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [7:0]    shift_reg, shift_next;
    logic          stop_sample;

    logic          overrun_reg, frame_err_reg, irq_reg;
    logic          ack_reg, pop_pend_reg;
    logic [1:0]    clr_pend_reg;
    logic [31:0]   rdt_reg;
    logic [31:0]   data_word, status_word;

    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_head;
    logic [AW:0]   fifo_count;
    logic          set_overrun, set_frame_err;
    logic          unused_dat;

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) sync_reg <= 2'b11;
        else          sync_reg <= {sync_reg[0], i_rx};
    end
    assign rx_s = sync_reg[1];

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_reg   <= RX_IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + 1'b1;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        stop_sample  = 1'b0;
        case (state_reg)
            RX_IDLE: begin
                cnt_next     = '0;
                bit_idx_next = '0;
                if (!rx_s) state_next = RX_START;
            end
            RX_START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (cnt_reg == CNT_HALF) begin
                    cnt_next   = '0;
                    state_next = rx_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rx_s, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 1'b1;
                    if (bit_idx_reg == 3'd7) state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_reg == CNT_LAST) begin
                    cnt_next    = '0;
                    stop_sample = 1'b1;
                    state_next  = RX_IDLE;
                end
            end
            default: state_next = RX_IDLE;
        endcase
    end

    assign fifo_pop      = ack_reg && pop_pend_reg;
    assign fifo_push     = stop_sample && rx_s && (!fifo_full || fifo_pop);
    assign set_overrun   = stop_sample && rx_s && fifo_full && !fifo_pop;
    assign set_frame_err = stop_sample && !rx_s;

    servant_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_wb_clk),
        .srst      (i_wb_rst),
        .push      (fifo_push),
        .push_data (shift_reg),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_comb begin
        data_word   = '0;
        status_word = '0;
        if (!fifo_empty) begin
            data_word[DATA_VALID_BIT] = 1'b1;
            data_word[7:0]            = fifo_head;
        end
        status_word[STAT_NOT_EMPTY]            = !fifo_empty;
        status_word[STAT_FULL]                 = fifo_full;
        status_word[STAT_OVERRUN]              = overrun_reg;
        status_word[STAT_FRAME_ERR]            = frame_err_reg;
        status_word[STAT_COUNT_LSB +: AW + 1]  = fifo_count;
    end

    // The access is decoded at request time; its pop/clear lands in the ack cycle.
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            ack_reg      <= 1'b0;
            rdt_reg      <= '0;
            pop_pend_reg <= 1'b0;
            clr_pend_reg <= 2'b00;
        end else begin
            ack_reg      <= wb.cyc && !ack_reg;
            rdt_reg      <= '0;
            pop_pend_reg <= 1'b0;
            clr_pend_reg <= 2'b00;
            if (wb.cyc && !ack_reg) begin
                if (wb.we) begin
                    if (wb.adr == REG_STATUS)
                        clr_pend_reg <= {wb.dat[STAT_FRAME_ERR], wb.dat[STAT_OVERRUN]};
                end else if (wb.adr == REG_DATA) begin
                    rdt_reg      <= data_word;
                    pop_pend_reg <= !fifo_empty;
                end else begin
                    rdt_reg <= status_word;
                end
            end
        end
    end

    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            overrun_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            irq_reg       <= 1'b0;
        end else begin
            overrun_reg   <= set_overrun   || (overrun_reg   && !(ack_reg && clr_pend_reg[0]));
            frame_err_reg <= set_frame_err || (frame_err_reg && !(ack_reg && clr_pend_reg[1]));
            irq_reg       <= !fifo_empty;
        end
    end

    assign unused_dat = ^{wb.dat[31:4], wb.dat[1:0]};
    assign wb.ack     = ack_reg;
    assign wb.rdt     = rdt_reg;
    assign o_irq      = irq_reg;

endmodule

// File: tb/tb_servant_uart_rx.sv
// Bench for servant_uart_rx at 8 clocks per bit with a 16-entry FIFO.
module tb_servant_uart_rx;
    localparam int CPB   = 8;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx  = 1'b1;
    logic irq;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];

    servant_uart_rx_if bus();

    servant_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_wb_clk (clk),
        .i_wb_rst (rst),
        .i_rx     (rx),
        .wb       (bus),
        .o_irq    (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wb_access(input logic a, input logic w, input logic [31:0] wd,
                             output logic [31:0] d);
        int n = 0;
        bus.cyc = 1'b1; bus.adr = a; bus.we = w; bus.dat = wd;
        @(negedge clk);
        while (!bus.ack && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (bus.ack !== 1'b1) begin
            bad++;
            $display("FAIL wb_ack_timeout got=%b exp=1", bus.ack);
        end
        d = bus.rdt;
        bus.cyc = 1'b0; bus.we = 1'b0; bus.dat = '0;
        @(negedge clk);
    endtask

    task automatic check_data(input string name);
        logic [31:0] d, exp;
        exp = 32'h0;
        if (sb.size() > 0) exp = {22'b0, 1'b1, 1'b0, sb.pop_front()};
        wb_access(1'b0, 1'b0, 32'h0, d);
        total++;
        if (d !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, d, exp);
        end
        $display("read DATA %s: %h", name, d);
    endtask

    task automatic check_status(input string name, input logic [31:0] exp);
        logic [31:0] d;
        wb_access(1'b1, 1'b0, 32'h0, d);
        total++;
        if (d !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, d, exp);
        end
        $display("read STATUS %s: %h", name, d);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        total++;
        if ({bus.ack, irq, bus.rdt} !== 34'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%b%b_%h exp=0", bus.ack, irq, bus.rdt);
        end
        rst = 1'b0;
        @(negedge clk);
        check_status("reset_status", 32'h0);
    endtask

    task automatic test_single_byte;
        send_frame(8'hA5, 1'b1);
        sb.push_back(8'hA5);
        repeat (3) @(negedge clk);
        check_status("single_status", 32'h0000_0101);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL single_irq got=%b exp=1", irq); end
        check_data("single_data");
        check_data("single_empty");
        repeat (2) @(negedge clk);
        total++;
        if (irq !== 1'b0) begin bad++; $display("FAIL single_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_glitch;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check_status("glitch_status", 32'h0);
    endtask

    task automatic test_frame_error;
        logic [31:0] d;
        send_frame(8'h3C, 1'b0);
        repeat (14) @(negedge clk);
        check_status("frame_status", 32'h0000_0008);
        wb_access(1'b1, 1'b1, 32'h8, d);
        check_status("frame_clear", 32'h0);
    endtask

    task automatic test_overrun;
        logic [31:0] d;
        for (int i = 0; i <= DEPTH; i++) begin
            send_frame(8'(i), 1'b1);
            if (i < DEPTH) sb.push_back(8'(i));
        end
        repeat (3) @(negedge clk);
        check_status("overrun_status", 32'h0000_1007);
        for (int i = 0; i < DEPTH; i++) check_data("overrun_drain");
        check_data("overrun_empty");
        wb_access(1'b1, 1'b1, 32'h4, d);
        check_status("overrun_clear", 32'h0);
    endtask

    task automatic test_push_pop;
        logic [31:0] d, exp;
        for (int i = 0; i < DEPTH; i++) begin
            send_frame(8'h40 + 8'(i), 1'b1);
            sb.push_back(8'h40 + 8'(i));
        end
        @(negedge clk);
        // The read's ack cycle is placed on the stop-bit sample of the next frame.
        fork
            send_frame(8'h99, 1'b1);
            begin
                repeat (2 + CPB / 2 + 9 * CPB) @(negedge clk);
                exp = {22'b0, 1'b1, 1'b0, sb.pop_front()};
                wb_access(1'b0, 1'b0, 32'h0, d);
                total++;
                if (d !== exp) begin bad++; $display("FAIL pushpop_data got=%h exp=%h", d, exp); end
                $display("read DATA pushpop_data: %h", d);
            end
        join
        sb.push_back(8'h99);
        repeat (3) @(negedge clk);
        check_status("pushpop_status", 32'h0000_1003);
        for (int i = 0; i < DEPTH; i++) check_data("pushpop_drain");
        check_status("pushpop_final", 32'h0);
    endtask

    task automatic test_reset_midframe;
        send_frame(8'h77, 1'b1);
        repeat (3) @(negedge clk);
        total++;
        if (irq !== 1'b1) begin bad++; $display("FAIL midframe_irq_pre got=%b exp=1", irq); end
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (30) @(negedge clk);
                rst = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    total++;
                    if ({bus.ack, irq, bus.rdt} !== 34'h0) begin
                        bad++;
                        $display("FAIL midframe_reset_outputs got=%b%b_%h exp=0", bus.ack, irq, bus.rdt);
                    end
                end
                rst = 1'b0;
            end
        join
        sb.delete();
        repeat (4) @(negedge clk);
        send_frame(8'h11, 1'b1);
        sb.push_back(8'h11);
        repeat (3) @(negedge clk);
        check_status("midframe_status", 32'h0000_0101);
        check_data("midframe_data");
        check_data("midframe_empty");
    endtask

    initial begin
        bus.cyc = 1'b0; bus.adr = 1'b0; bus.we = 1'b0; bus.dat = '0;
        test_reset();
        test_single_byte();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_push_pop();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
